// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: access FSM states and access owner.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        A_IDLE,
        A_ADDR,
        A_ACCESS,
        A_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DSP
    } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between CPU and display requests.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break, otherwise CPU priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dsp_req,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        valid  = cpu_req | dsp_req;
        winner = OWN_CPU;
        // on a tie, whoever did not own the previous access goes next
        if (dsp_req && (!cpu_req || last_owner == OWN_CPU)) begin
            winner = OWN_DSP;
        end
    end
`else
    logic unused_last_owner;

    assign unused_last_owner = (last_owner == OWN_DSP);

    always_comb begin
        valid  = cpu_req | dsp_req;
        winner = OWN_CPU;
        if (dsp_req && !cpu_req) begin
            winner = OWN_DSP;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the external RAM: CPU sequencer and display refresh.
// Build with ARB_ROUND_ROBIN_EN for round-robin ties; default is CPU priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    output logic              dsp_gnt,
    output logic              dsp_done,
    output logic [WORD_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              RAM_NCE,
    output logic              RAM_NOE,
    output logic              RAM_NWE,
    output logic              RAM_ADDRCP
);

    arb_state_t state;
    owner_t     owner;
    owner_t     last_owner;
    logic       we;
    logic       pick_valid;
    owner_t     pick_winner;

    ram_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dsp_req    (dsp_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= A_IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DSP;
            we         <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rdata      <= '0;
        end else begin
            unique case (state)
                // A_DONE re-arbitrates so back-to-back accesses take 3 cycles
                A_IDLE, A_DONE: begin
                    if (pick_valid) begin
                        state      <= A_ADDR;
                        owner      <= pick_winner;
                        last_owner <= pick_winner;
                        if (pick_winner == OWN_CPU) begin
                            ram_addr  <= cpu_addr;
                            ram_wdata <= cpu_wdata;
                            we        <= cpu_we;
                        end else begin
                            ram_addr <= dsp_addr;
                            we       <= 1'b0;
                        end
                    end else begin
                        state <= A_IDLE;
                    end
                end
                A_ADDR: begin
                    state <= A_ACCESS;
                end
                A_ACCESS: begin
                    state <= A_DONE;
                    if (!we) begin
                        rdata <= ram_rdata;
                    end
                end
            endcase
        end
    end

    always_comb begin
        RAM_ADDRCP = (state != A_ADDR);
        RAM_NCE    = (state != A_ACCESS);
        RAM_NOE    = !((state == A_ACCESS) && !we);
        RAM_NWE    = !((state == A_ACCESS) && we);
        cpu_gnt    = (state == A_ADDR) && (owner == OWN_CPU);
        dsp_gnt    = (state == A_ADDR) && (owner == OWN_DSP);
        cpu_done   = (state == A_DONE) && (owner == OWN_CPU);
        dsp_done   = (state == A_DONE) && (owner == OWN_DSP);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and scoreboard.
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       n_reset;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt;
    logic       cpu_done;
    logic       dsp_req;
    logic [7:0] dsp_addr;
    logic       dsp_gnt;
    logic       dsp_done;
    logic [7:0] rdata;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       RAM_NCE;
    logic       RAM_NOE;
    logic       RAM_NWE;
    logic       RAM_ADDRCP;

    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_rdata;
    int         ref_last;
    int         n_cmp;
    int         n_bad;

    ram_arbiter #(.WORD_W(8), .ADDR_W(8)) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_done   (cpu_done),
        .dsp_req    (dsp_req),
        .dsp_addr   (dsp_addr),
        .dsp_gnt    (dsp_gnt),
        .dsp_done   (dsp_done),
        .rdata      (rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .RAM_NCE    (RAM_NCE),
        .RAM_NOE    (RAM_NOE),
        .RAM_NWE    (RAM_NWE),
        .RAM_ADDRCP (RAM_ADDRCP)
    );

    always #5 clock = ~clock;

    assign ram_rdata = ram_mem[ram_addr];

    always @(posedge clock) begin
        if (!RAM_NCE && !RAM_NWE) ram_mem[ram_addr] <= ram_wdata;
    end

    // Expected winner: 0 = CPU, 1 = display
    function automatic int exp_pick(input bit c, input bit d);
        if (c && !d) return 0;
        if (d && !c) return 1;
`ifdef ARB_ROUND_ROBIN_EN
        return (ref_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic wait_gnt(output int w);
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!(cpu_gnt || dsp_gnt) && w < 10);
    endtask

    // Serve one or two pending requests through to completion
    task automatic serve(input bit c, input bit d, input bit cwe,
                         input logic [7:0] caddr, input logic [7:0] cwd,
                         input logic [7:0] daddr);
        bit         pc;
        bit         pd;
        int         w;
        int         e;
        bit         we;
        logic [7:0] a;
        pc = c;
        pd = d;
        cpu_req = c; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dsp_req = d; dsp_addr = daddr;
        while (pc || pd) begin
            e  = exp_pick(pc, pd);
            a  = (e == 0) ? caddr : daddr;
            we = (e == 0) ? cwe : 1'b0;
            wait_gnt(w);
            n_cmp++;
            if (w !== 1) begin
                n_bad++;
                $display("FAIL gnt_latency: got %0d cycles want 1", w);
            end
            n_cmp++;
            if ({cpu_gnt, dsp_gnt} !== ((e == 0) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL gnt_owner: got %b want owner %0d", {cpu_gnt, dsp_gnt}, e);
            end
            n_cmp++;
            if ({RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP, ram_addr} !== {4'b1110, a}) begin
                n_bad++;
                $display("FAIL addr_phase: got %b/%h want 1110/%h",
                         {RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP}, ram_addr, a);
            end
            ref_last = e;
            @(negedge clock);
            n_cmp++;
            if ({RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP} !== (we ? 4'b0101 : 4'b0011)) begin
                n_bad++;
                $display("FAIL access_strobes: got %b want %b",
                         {RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP}, we ? 4'b0101 : 4'b0011);
            end
            if (we) begin
                n_cmp++;
                if (ram_wdata !== cwd) begin
                    n_bad++;
                    $display("FAIL ram_wdata: got %h want %h", ram_wdata, cwd);
                end
            end
            @(negedge clock);
            if (we) ref_mem[a] = cwd;
            else    ref_rdata = ref_mem[a];
            n_cmp++;
            if ({cpu_done, dsp_done, RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP, rdata} !==
                {(e == 0) ? 2'b10 : 2'b01, 4'b1111, ref_rdata}) begin
                n_bad++;
                $display("FAIL done_phase: got done=%b strb=%b rdata=%h want owner %0d rdata=%h",
                         {cpu_done, dsp_done}, {RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP},
                         rdata, e, ref_rdata);
            end
            if (e == 0) begin cpu_req = 1'b0; pc = 1'b0; end
            else        begin dsp_req = 1'b0; pd = 1'b0; end
        end
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dsp_req = 1'b0; dsp_addr = '0;
        ref_rdata = '0;
        ref_last  = 1;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP, cpu_gnt, cpu_done, dsp_gnt, dsp_done,
             rdata, ram_addr, ram_wdata} !== {8'hF0, 24'h0}) begin
            n_bad++;
            $display("FAIL reset_values: strb=%b gd=%b rdata=%h addr=%h wdata=%h",
                     {RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP},
                     {cpu_gnt, cpu_done, dsp_gnt, dsp_done}, rdata, ram_addr, ram_wdata);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP, cpu_gnt, cpu_done, dsp_gnt, dsp_done}
                !== 8'hF0) begin
                n_bad++;
                $display("FAIL idle_cycle%0d: got %b want 11110000", i,
                         {RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP,
                          cpu_gnt, cpu_done, dsp_gnt, dsp_done});
            end
        end
    endtask

    task automatic test_cpu_read;
        ram_mem[8'h10] = 8'hA5;
        ref_mem[8'h10] = 8'hA5;
        serve(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00);
    endtask

    task automatic test_write_then_dsp_read;
        serve(1'b1, 1'b0, 1'b1, 8'h05, 8'h3C, 8'h00);
        serve(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h05);
    endtask

    task automatic test_drop_req;
        int w;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        wait_gnt(w);
        n_cmp++;
        if ({w == 1, cpu_gnt} !== 2'b11) begin
            n_bad++;
            $display("FAIL drop_gnt: got w=%0d gnt=%b want w=1 gnt=1", w, cpu_gnt);
        end
        ref_last = 0;
        cpu_req = 1'b0;
        repeat (2) @(negedge clock);
        ref_rdata = ref_mem[8'h10];
        n_cmp++;
        if ({cpu_done, rdata} !== {1'b1, ref_rdata}) begin
            n_bad++;
            $display("FAIL drop_done: got done=%b rdata=%h want 1/%h", cpu_done, rdata, ref_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP, cpu_gnt, cpu_done, dsp_gnt, dsp_done}
                !== 8'hF0) begin
                n_bad++;
                $display("FAIL drop_idle%0d: got %b want 11110000", i,
                         {RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP,
                          cpu_gnt, cpu_done, dsp_gnt, dsp_done});
            end
        end
    endtask

    task automatic test_contention;
        int w;
        int e;
        logic [7:0] ca;
        logic [7:0] da;
        ca = 8'($urandom);
        da = 8'($urandom);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
        dsp_req = 1'b1; dsp_addr = da;
        for (int g = 0; g < 6; g++) begin
            e = exp_pick(1'b1, 1'b1);
            wait_gnt(w);
            n_cmp++;
            if ({w == 1, cpu_gnt, dsp_gnt} !== {1'b1, (e == 0) ? 2'b10 : 2'b01}) begin
                n_bad++;
                $display("FAIL contend_gnt%0d: got w=%0d gnt=%b want owner %0d",
                         g, w, {cpu_gnt, dsp_gnt}, e);
            end
            ref_last = e;
            repeat (2) @(negedge clock);
            ref_rdata = ref_mem[(e == 0) ? ca : da];
            n_cmp++;
            if ({cpu_done, dsp_done, rdata} !== {(e == 0) ? 2'b10 : 2'b01, ref_rdata}) begin
                n_bad++;
                $display("FAIL contend_done%0d: got done=%b rdata=%h want owner %0d rdata=%h",
                         g, {cpu_done, dsp_done}, rdata, e, ref_rdata);
            end
        end
        cpu_req = 1'b0;
        dsp_req = 1'b0;
    endtask

    task automatic test_random;
        int mode;
        for (int t = 0; t < 30; t++) begin
            mode = $urandom_range(0, 2);
            serve(mode != 1, mode != 0, 1'($urandom), 8'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_access;
        int w;
        ram_mem[8'h20] = 8'h5A;
        ref_mem[8'h20] = 8'h5A;
        serve(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21;
        wait_gnt(w);
        @(posedge clock);
        #2;
        n_cmp++;
        if ({w == 1, RAM_NCE} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_access_enter: got w=%0d nce=%b want w=1 nce=0", w, RAM_NCE);
        end
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP, cpu_gnt, cpu_done, dsp_gnt, dsp_done,
             rdata} !== {8'hF0, 8'h00}) begin
            n_bad++;
            $display("FAIL async_reset: got strb/gd=%b rdata=%h want 11110000/00",
                     {RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP,
                      cpu_gnt, cpu_done, dsp_gnt, dsp_done}, rdata);
        end
        ref_rdata = '0;
        ref_last  = 1;
        cpu_req   = 1'b0;
        repeat (2) @(negedge clock);
        n_reset = 1'b1;
        serve(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h05);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        test_reset();
        test_idle();
        test_cpu_read();
        test_write_then_dsp_read();
        test_drop_req();
        test_contention();
        test_random();
        test_reset_mid_access();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single external RAM between two requesters: the CPU sequencer port and a display-refresh reader that fetches digit codes for the seven-segment scanner. The block owns the RAM control strobes (RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP), the RAM address and the write data. Each access runs through a fixed four-state cycle and completes with a done pulse. It sits between the processor/display logic and the RAM macro.

## Interface
- WORD_W, 8, data width
- ADDR_W, 8, RAM address width
- clock  in  1  system clock, all state changes on rising edge
- n_reset  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- cpu_req  in  1  CPU access request, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  WORD_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse when a CPU access is accepted
- cpu_done  out  1  one-cycle pulse when the CPU access completes
- dsp_req  in  1  display read request, held until dsp_done
- dsp_addr  in  ADDR_W  display read address
- dsp_gnt  out  1  one-cycle pulse when a display access is accepted
- dsp_done  out  1  one-cycle pulse when the display access completes
- rdata  out  WORD_W  read data captured from RAM, shared by both requesters
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  WORD_W  RAM write data
- ram_rdata  in  WORD_W  RAM read data
- RAM_NCE, RAM_NOE, RAM_NWE, RAM_ADDRCP  out  1 each  active-low RAM strobes

## Operation
- FSM states: A_IDLE, A_ADDR, A_ACCESS, A_DONE.
- A_IDLE:
  - If any request is present, pick a winner.
  - Latch the owner, address, we and wdata (display: we=0) into registers.
  - Pulse the winner's gnt and go to A_ADDR. Otherwise stay in A_IDLE.
- A_ADDR: RAM_ADDRCP=0 and ram_addr driven from the latch. Go to A_ACCESS.
- A_ACCESS:
  - RAM_NCE=0.
  - Read: RAM_NOE=0, and rdata is captured from ram_rdata at the end of this cycle.
  - Write: RAM_NWE=0 and ram_wdata driven. rdata is unchanged.
  - Go to A_DONE.
- A_DONE:
  - Pulse the owner's done.
  - Re-arbitrate in this same cycle. A winner causes a gnt pulse and a move to A_ADDR (back-to-back); no request returns to A_IDLE.
- Arbitration (round-robin variant): when both request, the requester that did not own the last access wins. last_owner updates on each grant.
- A request deasserted mid-access does not abort it. The access completes and done still pulses.
- RAM strobes and gnt/done are Moore outputs, decoded from registered state and owner only. They never depend combinationally on req inputs.
- Reset values:
  - State A_IDLE.
  - All four RAM strobes 1; gnt and done 0.
  - rdata, ram_addr and ram_wdata all 0.
  - last_owner = display, so the CPU wins the first tie.
- Reset asserted mid-access: strobes go inactive immediately, with no done pulse.

## Timing
- Request sampled high in A_IDLE at edge k:
  - gnt high in cycle k+1 (A_ADDR).
  - RAM enabled in k+2 (A_ACCESS).
  - done and rdata valid from k+3.
  - Latency is 3 cycles.
- rdata holds until the next read's capture.
- Back-to-back accesses: 3 cycles per access.
- Requester rule: drop req in the cycle after done, or keep it high to request again.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin tie-break as above.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the CPU always wins ties.
  - The display can starve under continuous CPU requests.
  - last_owner logic is omitted.

## Structure
- Package ram_arb_pkg holds:
  - typedef enum arb_state_t {A_IDLE, A_ADDR, A_ACCESS, A_DONE}.
  - typedef enum owner_t {OWN_CPU, OWN_DSP}.
- Sub-module ram_arb_pick: combinational winner select from (cpu_req, dsp_req, last_owner). It contains the only ARB_ROUND_ROBIN_EN conditional.

## Test plan
- CPU read, address 8'h10 holding 8'hA5: cpu_req at edge 0 -> cpu_gnt in cycle 1, RAM_ADDRCP=0 in cycle 1, RAM_NCE=RAM_NOE=0 in cycle 2, cpu_done and rdata=8'hA5 in cycle 3.
- CPU write 8'h3C to 8'h05, then display read of 8'h05 -> RAM_NWE=0 for exactly one cycle; dsp_done with rdata=8'h3C.
- Both requests held continuously, round-robin build -> grants alternate CPU, DSP, CPU, DSP, one done every 3 cycles. Fixed-priority build -> CPU only.
- cpu_req dropped during A_ADDR -> access still completes and cpu_done pulses once, then the FSM returns to A_IDLE.
- n_reset asserted during A_ACCESS -> strobes 1, gnt/done 0 and rdata 0 with no clock edge. After release, the first tie is granted to the CPU.
- No requests for 20 cycles -> FSM stays in A_IDLE and all RAM strobes stay 1.
